// File: rtl/positron_layer_sequencer.sv
// rtl/positron_layer_sequencer.sv - streams one activation window to a positron bank
// and gathers the per-neuron results into an output vector.
module positron_layer_sequencer #(
  parameter int POSIT_WIDTH = 4,
  parameter int NB_INPUTS   = 784,
  parameter int NB_NEURONS  = 16,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             act_rd_o,
  output logic [ADDR_WIDTH-1:0]            act_addr_o,
  input  logic [POSIT_WIDTH-1:0]           act_data_i,
  output logic                             pos_rts_o,
  output logic                             pos_sow_o,
  output logic                             pos_eow_o,
  output logic [POSIT_WIDTH-1:0]           pos_posit_o,
  input  logic [NB_NEURONS-1:0]            pos_rtr_i,
  input  logic [NB_NEURONS-1:0]            res_rts_i,
  input  logic [NB_NEURONS*POSIT_WIDTH-1:0] res_posit_i,
  output logic                             res_rtr_o,
  output logic                             out_valid_o,
  output logic [NB_NEURONS*POSIT_WIDTH-1:0] out_data_o,
  input  logic                             out_ready_i
);

  localparam logic [ADDR_WIDTH:0] LP_NB   = (ADDR_WIDTH+1)'(NB_INPUTS);
  localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(NB_INPUTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_COLLECT, S_OUTPUT} state_t;

  state_t                           r_state, w_next;
  logic [ADDR_WIDTH:0]              r_rd_cnt;
  logic [ADDR_WIDTH:0]              r_beat_idx;
  logic                             r_inflight;
  logic [POSIT_WIDTH-1:0]           r_fifo [2];
  logic                             r_wr_ptr, r_rd_ptr;
  logic [1:0]                       r_occ;
  logic                             r_bc_valid, r_bc_sow, r_bc_eow;
  logic [POSIT_WIDTH-1:0]           r_bc_data;
  logic [NB_NEURONS-1:0]            r_flags;
  logic [NB_NEURONS*POSIT_WIDTH-1:0] r_out_data;

  logic                   w_stream, w_xfer, w_bc_free, w_load, w_bypass, w_push, w_pop, w_rd;
  logic [2:0]             w_level;
  logic [POSIT_WIDTH-1:0] w_load_data;
  logic [NB_NEURONS-1:0]  w_new;

  assign w_stream  = (r_state == S_STREAM);
  assign w_xfer    = r_bc_valid && (&pos_rtr_i);
  assign w_bc_free = !r_bc_valid || w_xfer;
  // Data returning into an empty FIFO goes straight to the broadcast register,
  // which is what gives the 2-cycle start-up latency.
  assign w_load    = w_stream && w_bc_free && ((r_occ != 2'd0) || r_inflight);
  assign w_bypass  = w_load && (r_occ == 2'd0);
  assign w_push    = r_inflight && !w_bypass;
  assign w_pop     = w_load && (r_occ != 2'd0);
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_load};
  assign w_rd      = w_stream && (r_rd_cnt < LP_NB) && (w_level < 3'd2);
  assign w_load_data = w_bypass ? act_data_i : r_fifo[r_rd_ptr];
  assign w_new     = res_rts_i & ~r_flags;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_next = S_STREAM;
      S_STREAM:  if (w_xfer && r_bc_eow) w_next = S_COLLECT;
      S_COLLECT: if (&(r_flags | res_rts_i)) w_next = S_OUTPUT;
      S_OUTPUT:  if (out_ready_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_cnt   <= '0;
      r_beat_idx <= '0;
      r_inflight <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_occ      <= '0;
      r_bc_valid <= 1'b0;
      r_bc_sow   <= 1'b0;
      r_bc_eow   <= 1'b0;
      r_bc_data  <= '0;
      r_flags    <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start_i) begin
        r_rd_cnt   <= '0;
        r_beat_idx <= '0;
        r_inflight <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
        r_occ      <= '0;
        r_bc_valid <= 1'b0;
        r_flags    <= '0;
      end else begin
        r_inflight <= w_rd;
        if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_push) begin
          r_fifo[r_wr_ptr] <= act_data_i;
          r_wr_ptr         <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
        r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        if (w_load) begin
          r_bc_valid <= 1'b1;
          r_bc_data  <= w_load_data;
          r_bc_sow   <= (r_beat_idx == '0);
          r_bc_eow   <= (r_beat_idx == LP_LAST);
          r_beat_idx <= r_beat_idx + 1'b1;
        end else if (w_xfer) begin
          r_bc_valid <= 1'b0;
        end
        if (r_state == S_COLLECT) begin
          r_flags <= r_flags | res_rts_i;
          for (int k = 0; k < NB_NEURONS; k++) begin
            if (w_new[k]) r_out_data[k*POSIT_WIDTH +: POSIT_WIDTH] <= res_posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
          end
        end
      end
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign act_rd_o    = w_rd;
  assign act_addr_o  = w_rd ? r_rd_cnt[ADDR_WIDTH-1:0] : '0;
  assign pos_rts_o   = r_bc_valid;
  assign pos_sow_o   = r_bc_valid & r_bc_sow;
  assign pos_eow_o   = r_bc_valid & r_bc_eow;
  assign pos_posit_o = r_bc_data;
  assign res_rtr_o   = (r_state == S_COLLECT);
  assign out_valid_o = (r_state == S_OUTPUT);
  assign done_o      = out_valid_o & out_ready_i;
  assign out_data_o  = r_out_data;

endmodule

// File: doc/positron_layer_sequencer.md
Name: positron_layer_sequencer

Overview:
- Sequences one fully-connected layer built from NB_NEURONS positron engines sharing a single activation stream.
- Fetches NB_INPUTS activations from an activation buffer (1-cycle read latency) and broadcasts them as one window framed with sow/eow, under rts/rtr handshake.
- Collects each neuron's end-of-window result into an output vector and hands the vector downstream.
- Sits between the layer's activation memory and the positron bank; one instance per layer.

Parameters:
- POSIT_WIDTH, 4, posit word width.
- NB_INPUTS, 784, activations per window; must be >= 2.
- NB_NEURONS, 16, positrons in the bank.
- ADDR_WIDTH, 10, activation address width; 2**ADDR_WIDTH >= NB_INPUTS.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin one layer pass; sampled only in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the output vector is accepted.
- act_rd_o  out  1  activation read strobe.
- act_addr_o  out  ADDR_WIDTH  read address; data returns on act_data_i the next cycle.
- act_data_i  in  POSIT_WIDTH  activation read data.
- pos_rts_o  out  1  broadcast beat valid.
- pos_sow_o  out  1  first beat of window.
- pos_eow_o  out  1  last beat of window.
- pos_posit_o  out  POSIT_WIDTH  broadcast activation.
- pos_rtr_i  in  NB_NEURONS  per-positron ready.
- res_rts_i  in  NB_NEURONS  per-positron result valid (end of window).
- res_posit_i  in  NB_NEURONS*POSIT_WIDTH  results; neuron k occupies bits [k*POSIT_WIDTH +: POSIT_WIDTH].
- res_rtr_o  out  1  ready to positron outputs.
- out_valid_o  out  1  result vector valid.
- out_data_o  out  NB_NEURONS*POSIT_WIDTH  captured result vector.
- out_ready_i  in  1  downstream accept.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, counters, FIFO and capture flags are cleared. A reset mid-pass abandons the pass, with no done_o.
- Beat transfer: a beat transfers when pos_rts_o is high and &pos_rtr_i is high. pos_posit_o, pos_sow_o and pos_eow_o hold stable while pos_rts_o is high and the bank is not ready.
- FSM states: IDLE, STREAM, COLLECT, OUTPUT.
- IDLE -> STREAM when start_i is high. On entry: read address = 0, beat count = 0, flags cleared. start_i outside IDLE is ignored.
- STREAM prefetch:
  - A 2-entry prefetch FIFO feeds the broadcast register.
  - act_rd_o is asserted when reads issued < NB_INPUTS and (FIFO occupancy + reads in flight − pop this cycle) < 2.
  - act_addr_o increments per read, from 0 to NB_INPUTS−1.
  - Returned data is pushed into the FIFO one cycle after its read.
  - Sustained throughput is 1 beat/cycle with the bank always ready. The first pos_rts_o appears 2 cycles after entering STREAM.
- STREAM framing: pos_sow_o = 1 on beat index 0 only; pos_eow_o = 1 on beat index NB_INPUTS−1 only. Exactly NB_INPUTS beats are sent per pass.
- STREAM -> COLLECT on the cycle the eow beat transfers. pos_rts_o drops to 0 the following cycle.
- COLLECT:
  - res_rtr_o = 1.
  - For each k with res_rts_i[k] high and flag[k] clear: capture slice k into out_data_o and set flag[k].
  - A repeated res_rts_i[k] after capture is ignored.
  - Captures may arrive in any order and on any cycle, including several in the same cycle.
  - When all flags are set (including those set this cycle), go to OUTPUT next cycle with res_rtr_o = 0.
- OUTPUT: out_valid_o = 1 and out_data_o is held stable. On out_ready_i, pulse done_o for one cycle and go to IDLE. out_valid_o falls the same edge.
- out_data_o keeps its last value in IDLE.
- res_rts_i asserted outside COLLECT is ignored; res_rtr_o is 0 there.

Test Plan:
- NB_INPUTS=4, NB_NEURONS=2, memory[0..3]=0x1,0x2,0x3,0x4, bank always ready, start pulse -> beats 0x1..0x4 on 4 consecutive cycles; sow on 0x1 only, eow on 0x4 only; exactly 4 act_rd_o pulses at addresses 0..3.
- Same setup, pos_rtr_i=2'b01 for 3 cycles during beat 0x2 -> 0x2 and its flags held stable; no beat lost or duplicated; act_rd_o never overfills the FIFO (occupancy ≤ 2).
- After eow, res_rts_i[1]=1 with data 0xA, then res_rts_i[0]=1 with data 0x5 two cycles later -> out_data_o=0xA5, out_valid_o asserted the cycle after the second capture.
- Both res_rts_i asserted in the same cycle with 0x3/0xC -> single capture, out_data_o=0xC3; a duplicate res_rts_i[0] with 0xF the next cycle is ignored.
- OUTPUT with out_ready_i=0 for 5 cycles then 1 -> out_valid_o held 6 cycles, done_o pulses once, busy_o falls; start_i pulsed mid-STREAM has no effect.
- rst asserted during STREAM after 2 beats -> all outputs 0 next cycle, no done_o; a new start_i restarts at address 0 with sow on the first beat.
